// File: rtl/serial_link_scheduler.sv
// -----------------------------------------------------------------------------
// serial_link_scheduler
//
// Shares one serial bit line among NREQ requesters. Requests are arbitrated
// round-robin while idle. The winner's parallel word is then shifted out MSB
// first, followed by an idle gap of GAP_CYCLES cycles, before the block
// arbitrates again.
//
// Handshake: req[i] is a level request that is sampled only in IDLE. The grant
// edge captures word slice i and answers with a one-cycle ack[i] pulse. There
// is no backpressure on the serial side. A requester with one word drops
// req[i] when it sees ack[i]. A req[i] that is still high when the block
// returns to IDLE counts as a new request.
//
// Ports:
//   clk_2         in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   req           in   [NREQ]            level request per requester
//   word          in   [NREQ*WORD_BITS]  requester i word at [i*WORD_BITS +: WORD_BITS]
//   ack           out  [NREQ]            one-hot grant pulse (first SHIFT cycle)
//   owner         out  [clog2(NREQ)]     current / last granted requester
//   serial_out    out                    serial data bit
//   serial_valid  out                    high while a data bit is driven
//   busy          out                    high in SHIFT and GAP
//   frame_done    out                    one-cycle pulse after the last bit
// All outputs are registered.
// -----------------------------------------------------------------------------
module serial_link_scheduler #(
    parameter int NREQ       = 4,
    parameter int WORD_BITS  = 4,
    parameter int GAP_CYCLES = 1
) (
    input  logic                      clk_2,
    input  logic                      reset,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WORD_BITS-1:0] word,
    output logic [NREQ-1:0]           ack,
    output logic [$clog2(NREQ)-1:0]   owner,
    output logic                      serial_out,
    output logic                      serial_valid,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int OW    = $clog2(NREQ);
    localparam int CNT_W = $clog2(WORD_BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [OW-1:0]          last_q, last_d;
    logic [OW-1:0]          owner_q, owner_d;
    logic [NREQ-1:0]        ack_q, ack_d;
    logic [WORD_BITS-1:0]   shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   serial_out_q, serial_out_d;
    logic                   serial_valid_q, serial_valid_d;
    logic                   busy_q, busy_d;
    logic                   frame_done_q, frame_done_d;

    // Arbitration results
    logic                   found;
    logic [OW-1:0]          winner;
    logic [NREQ-1:0]        winner_onehot;
    logic [WORD_BITS-1:0]   winner_word;
    int                     idx;

    // Round-robin search: start just after the last winner and take the first
    // requester found, wrapping modulo NREQ.
    always_comb begin
        found         = 1'b0;
        winner        = '0;
        winner_onehot = '0;
        winner_word   = '0;
        idx           = 0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(last_q) + off) % NREQ;
            if (!found && req[idx]) begin
                found              = 1'b1;
                winner             = OW'(idx);
                winner_onehot[idx] = 1'b1;
                winner_word        = word[idx*WORD_BITS +: WORD_BITS];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        last_d         = last_q;
        owner_d        = owner_q;
        ack_d          = '0;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        gap_cnt_d      = gap_cnt_q;
        serial_out_d   = serial_out_q;
        serial_valid_d = serial_valid_q;
        busy_d         = busy_q;
        frame_done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                serial_out_d   = 1'b0;
                serial_valid_d = 1'b0;
                busy_d         = 1'b0;
                if (found) begin
                    // The MSB goes out on the grant edge. The register keeps
                    // the remaining bits left-aligned, so the next bit is
                    // always its top bit.
                    shift_d        = winner_word << 1;
                    serial_out_d   = winner_word[WORD_BITS-1];
                    serial_valid_d = 1'b1;
                    busy_d         = 1'b1;
                    owner_d        = winner;
                    last_d         = winner;
                    ack_d          = winner_onehot;
                    bit_cnt_d      = CNT_W'(1);
                    state_d        = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // bit_cnt_q counts bits already driven, including the current one
                if (bit_cnt_q == CNT_W'(WORD_BITS)) begin
                    serial_out_d   = 1'b0;
                    serial_valid_d = 1'b0;
                    frame_done_d   = 1'b1;
                    bit_cnt_d      = '0;
                    gap_cnt_d      = GAP_W'(1);
                    state_d        = ST_GAP;
                end else begin
                    serial_out_d = shift_q[WORD_BITS-1];
                    shift_d      = shift_q << 1;
                    bit_cnt_d    = bit_cnt_q + CNT_W'(1);
                end
            end

            ST_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CYCLES)) begin
                    busy_d    = 1'b0;
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end

            default: begin
                state_d        = ST_IDLE;
                serial_out_d   = 1'b0;
                serial_valid_d = 1'b0;
                busy_d         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            last_q         <= OW'(NREQ - 1);
            owner_q        <= '0;
            ack_q          <= '0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            gap_cnt_q      <= '0;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_q         <= last_d;
            owner_q        <= owner_d;
            ack_q          <= ack_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            gap_cnt_q      <= gap_cnt_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            busy_q         <= busy_d;
            frame_done_q   <= frame_done_d;
        end
    end

    assign ack          = ack_q;
    assign owner        = owner_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign busy         = busy_q;
    assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_serial_link_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_link_scheduler
//
// Bench for serial_link_scheduler at default parameters. A frame-level model
// tracks grants: when each frame started, who owns it and which word was
// captured. It derives the expected per-cycle outputs from the offset into
// the current frame. Inputs change on the falling edge, and outputs are
// checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_link_scheduler;

    localparam int NREQ   = 4;
    localparam int WB     = 4;
    localparam int GAP    = 1;
    localparam int OW     = $clog2(NREQ);
    localparam int PERIOD = WB + GAP + 1;

    logic                 clk_2 = 1'b0;
    logic                 reset = 1'b1;
    logic [NREQ-1:0]      req   = '0;
    logic [NREQ*WB-1:0]   word  = '0;
    logic [NREQ-1:0]      ack;
    logic [OW-1:0]        owner;
    logic                 serial_out;
    logic                 serial_valid;
    logic                 busy;
    logic                 frame_done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_2 = ~clk_2;

    serial_link_scheduler #(
        .NREQ       (NREQ),
        .WORD_BITS  (WB),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk_2        (clk_2),
        .reset        (reset),
        .req          (req),
        .word         (word),
        .ack          (ack),
        .owner        (owner),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .frame_done   (frame_done)
    );

    // ---------------- frame-level reference model ----------------
    int              cyc       = 0;
    int              m_last    = NREQ - 1;
    int              m_owner   = 0;
    logic [WB-1:0]   m_word    = '0;
    int              m_start   = 0;
    int              m_next    = 0;   // first edge at which req can be sampled
    bit              m_active  = 1'b0;
    int              m_d;
    logic [NREQ-1:0] exp_ack   = '0;
    logic [OW-1:0]   exp_owner = '0;
    logic            exp_so    = 1'b0;
    logic            exp_sv    = 1'b0;
    logic            exp_busy  = 1'b0;
    logic            exp_fd    = 1'b0;

    always @(posedge clk_2) begin
        cyc = cyc + 1;
        if (reset) begin
            m_last   = NREQ - 1;
            m_owner  = 0;
            m_active = 1'b0;
            m_next   = cyc + 1;
        end else if (cyc >= m_next && req != '0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_last + k) % NREQ;
                if (req[j]) begin
                    m_last   = j;
                    m_owner  = j;
                    m_word   = word[j*WB +: WB];
                    m_start  = cyc;
                    m_active = 1'b1;
                    m_next   = cyc + WB + GAP + 1;
                    break;
                end
            end
        end
        m_d       = cyc - m_start;
        exp_ack   = '0;
        exp_so    = 1'b0;
        exp_sv    = 1'b0;
        exp_busy  = 1'b0;
        exp_fd    = 1'b0;
        exp_owner = OW'(m_owner);
        if (m_active) begin
            if (m_d == 0) exp_ack[m_owner] = 1'b1;
            if (m_d < WB) begin
                exp_sv = 1'b1;
                exp_so = m_word[WB-1-m_d];
            end
            if (m_d == WB) exp_fd = 1'b1;
            if (m_d < WB + GAP) exp_busy = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clk_2);
        reset = 1'b1;
        req   = '0;
        repeat (2) @(negedge clk_2);
        reset = 1'b0;
    endtask

    task automatic wait_ack(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_2);
            if (ack != '0) got = 1'b1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bit got;
        @(negedge clk_2);
        reset = 1'b1;
        req   = '1;
        word  = NREQ*WB'($urandom);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_2);
            n_cmp++;
            if ({ack, owner, serial_out, serial_valid, busy, frame_done} !== '0) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d got ack=%b owner=%0d so=%b sv=%b busy=%b fd=%b want all 0",
                         i, ack, owner, serial_out, serial_valid, busy, frame_done);
            end
        end
        reset = 1'b0;
        wait_ack(3, got);
        n_cmp++;
        if (!got || ack !== 4'b0001 || owner !== 2'd0) begin
            n_bad++;
            $display("FAIL reset_first_grant got=%0b ack=%b owner=%0d want ack=0001 owner=0", got, ack, owner);
        end
    endtask

    task automatic test_single_frame();
        bit got;
        logic [WB-1:0] bits;
        logic sv_all;
        do_reset();
        word          = NREQ*WB'($urandom);
        word[WB +: WB] = 4'b1101;
        req           = 4'b0010;
        wait_ack(3, got);
        n_cmp++;
        if (!got || ack !== 4'b0010 || owner !== 2'd1) begin
            n_bad++;
            $display("FAIL single_grant got=%0b ack=%b owner=%0d want ack=0010 owner=1", got, ack, owner);
        end
        req     = '0;
        bits[3] = serial_out;
        sv_all  = serial_valid;
        for (int k = 2; k >= 0; k--) begin
            @(negedge clk_2);
            bits[k] = serial_out;
            sv_all  = sv_all & serial_valid;
            n_cmp++;
            if (ack !== '0) begin
                n_bad++;
                $display("FAIL single_ack_width ack=%b want 0000", ack);
            end
        end
        n_cmp++;
        if (bits !== 4'b1101 || sv_all !== 1'b1) begin
            n_bad++;
            $display("FAIL single_bits bits=%b valid=%b want 1101 valid=1", bits, sv_all);
        end
        @(negedge clk_2);
        n_cmp++;
        if (frame_done !== 1'b1 || serial_valid !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_done fd=%b sv=%b busy=%b want fd=1 sv=0 busy=1", frame_done, serial_valid, busy);
        end
        @(negedge clk_2);
        n_cmp++;
        if (busy !== 1'b0 || frame_done !== 1'b0) begin
            n_bad++;
            $display("FAIL single_idle busy=%b fd=%b want 0 0", busy, frame_done);
        end
    endtask

    task automatic test_simultaneous();
        int n_ack;
        int own[2];
        int when[2];
        do_reset();
        req   = 4'b0101;
        n_ack = 0;
        for (int i = 0; i < 20 && n_ack < 2; i++) begin
            @(negedge clk_2);
            if (ack != '0) begin
                own[n_ack]  = int'(owner);
                when[n_ack] = cyc;
                n_ack++;
                req = req & ~ack;
            end
        end
        n_cmp++;
        if (n_ack != 2) begin
            n_bad++;
            $display("FAIL simul_count acks=%0d want 2", n_ack);
        end else begin
            n_cmp++;
            if (own[0] != 0 || own[1] != 2) begin
                n_bad++;
                $display("FAIL simul_order got %0d,%0d want 0,2", own[0], own[1]);
            end
            n_cmp++;
            if (when[1] - when[0] != PERIOD) begin
                n_bad++;
                $display("FAIL simul_spacing got %0d want %0d", when[1] - when[0], PERIOD);
            end
        end
    endtask

    task automatic test_rotation();
        int n_ack;
        int prev;
        do_reset();
        req   = '1;
        n_ack = 0;
        prev  = 0;
        for (int i = 0; i < 40 && n_ack < 5; i++) begin
            @(negedge clk_2);
            if (ack != '0) begin
                n_cmp++;
                if (int'(owner) != n_ack % NREQ) begin
                    n_bad++;
                    $display("FAIL rot_owner grant=%0d got %0d want %0d", n_ack, owner, n_ack % NREQ);
                end
                if (n_ack > 0) begin
                    n_cmp++;
                    if (cyc - prev != PERIOD) begin
                        n_bad++;
                        $display("FAIL rot_spacing grant=%0d got %0d want %0d", n_ack, cyc - prev, PERIOD);
                    end
                end
                prev = cyc;
                n_ack++;
            end
        end
        n_cmp++;
        if (n_ack != 5) begin
            n_bad++;
            $display("FAIL rot_count acks=%0d want 5", n_ack);
        end
        req = '0;
    endtask

    task automatic test_mid_frame_reset();
        bit got;
        do_reset();
        word = NREQ*WB'($urandom);
        req  = 4'b1000;
        wait_ack(3, got);
        n_cmp++;
        if (!got || owner !== 2'd3) begin
            n_bad++;
            $display("FAIL mid_grant got=%0b owner=%0d want owner=3", got, owner);
        end
        req = '0;
        repeat (2) @(negedge clk_2);   // now in bit 2
        reset = 1'b1;
        @(negedge clk_2);
        n_cmp++;
        if ({ack, owner, serial_out, serial_valid, busy, frame_done} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs ack=%b owner=%0d so=%b sv=%b busy=%b fd=%b want all 0",
                     ack, owner, serial_out, serial_valid, busy, frame_done);
        end
        reset = 1'b0;
        req   = 4'b1001;
        wait_ack(3, got);
        n_cmp++;
        if (!got || ack !== 4'b0001 || owner !== 2'd0) begin
            n_bad++;
            $display("FAIL mid_regrant got=%0b ack=%b owner=%0d want ack=0001 owner=0", got, ack, owner);
        end
        req = '0;
    endtask

    task automatic test_late_req_word_change();
        bit got;
        int extra;
        logic [WB-1:0] w;
        logic [WB-1:0] bits;
        do_reset();
        w              = WB'($urandom);
        word           = NREQ*WB'($urandom);
        word[WB +: WB] = w;
        req            = 4'b0010;
        wait_ack(3, got);
        n_cmp++;
        if (!got || owner !== 2'd1) begin
            n_bad++;
            $display("FAIL late_grant got=%0b owner=%0d want owner=1", got, owner);
        end
        req            = '0;
        word[WB +: WB] = ~w;
        bits[WB-1]     = serial_out;
        for (int k = WB - 2; k >= 0; k--) begin
            @(negedge clk_2);
            bits[k] = serial_out;
            req[2]  = (k == WB - 2);   // one-cycle pulse, fully inside SHIFT
        end
        req = '0;
        n_cmp++;
        if (bits !== w) begin
            n_bad++;
            $display("FAIL late_word bits=%b want %b", bits, w);
        end
        extra = 0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            @(negedge clk_2);
            if (ack != '0) extra++;
        end
        n_cmp++;
        if (extra != 0) begin
            n_bad++;
            $display("FAIL late_pulse_grant acks=%0d want 0", extra);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_2);
            n_cmp++;
            if ({ack, owner, serial_out, serial_valid, busy, frame_done} !==
                {exp_ack, exp_owner, exp_so, exp_sv, exp_busy, exp_fd}) begin
                n_bad++;
                $display("FAIL random cyc=%0d got ack=%b own=%0d so=%b sv=%b busy=%b fd=%b want ack=%b own=%0d so=%b sv=%b busy=%b fd=%b",
                         cyc, ack, owner, serial_out, serial_valid, busy, frame_done,
                         exp_ack, exp_owner, exp_so, exp_sv, exp_busy, exp_fd);
            end
            for (int r = 0; r < NREQ; r++) begin
                if (ack[r]) req[r] = 1'b0;
                else if ($urandom_range(0, 3) == 0) req[r] = 1'($urandom_range(0, 1));
            end
            word  = NREQ*WB'($urandom);
            reset = ($urandom_range(0, 99) == 0);
        end
        reset = 1'b0;
        req   = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_simultaneous();
        test_rotation();
        test_mid_frame_reset();
        test_late_req_word_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_link_scheduler.md
# serial_link_scheduler

Round-robin scheduler that shares one serial bit line among `NREQ` requesters. Each requester presents a parallel word. The block grants one requester at a time and shifts that word out MSB first, followed by an idle gap, then re-arbitrates. `serial_out` feeds the serial input of the board-level pattern-detector FSM, so several switch-driven sources can take turns driving that detector.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8).
- `WORD_BITS`, 4, bits per word (1..16).
- `GAP_CYCLES`, 1, idle cycles after each word (1..15).

Ports:
- `clk_2`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  `NREQ`  level request per requester.
- `word`  in  `NREQ*WORD_BITS`  requester i's word at `[i*WORD_BITS +: WORD_BITS]`.
- `ack`  out  `NREQ`  one-hot, one-cycle pulse to the granted requester.
- `owner`  out  `$clog2(NREQ)`  index of the current or last granted requester.
- `serial_out`  out  1  serial data bit.
- `serial_valid`  out  1  high while a data bit is driven.
- `busy`  out  1  high in SHIFT and GAP states.
- `frame_done`  out  1  one-cycle pulse after the last bit of a word.

## Operation
- All outputs are registered.
- Reset values: `ack=0`, `owner=0`, `serial_out=0`, `serial_valid=0`, `busy=0`, `frame_done=0`, state `IDLE`, priority pointer `last=NREQ-1`, bit counter 0.
- States:
  - `IDLE`: `req` is sampled only here. If any bit is set, the winner is the first set bit searching `last+1, last+2, …` modulo `NREQ`. On that edge:
    - latch the winner's word into the shift register;
    - `owner<=winner`, `last<=winner`, `ack<=onehot(winner)`;
    - `serial_out<=word[WORD_BITS-1]`, `serial_valid<=1`, `busy<=1`;
    - go to `SHIFT`.
    If no bit is set, stay in `IDLE` with all outputs 0 except `owner`, which holds.
  - `SHIFT`: each edge drives the next lower bit. After `WORD_BITS` cycles with `serial_valid=1`, go to `GAP`: `serial_valid<=0`, `serial_out<=0`, `frame_done<=1` for one cycle.
  - `GAP`: lasts `GAP_CYCLES` cycles with `busy=1`, then go to `IDLE` with `busy<=0`.
- `ack` is high only in the first `SHIFT` cycle.
- A requester with a single word drops `req` on seeing `ack`. A `req` still high when the block returns to `IDLE` is a new request.
- `word` is sampled only on the grant edge. Later changes do not affect the word in flight.
- `req` bits that rise and fall while the block is not in `IDLE` are never seen.
- `reset` has priority over all other events. Asserting it mid-frame aborts the frame: outputs return to reset values on that edge, no `frame_done` is issued, and the pointer returns to `NREQ-1`.

## Timing
- Grant latency: `req` high at edge t while in `IDLE` gives the first bit and `ack` in cycle t+1.
- Bit k of the word (k=0 is the MSB) is valid in cycle t+1+k.
- `frame_done` is high in cycle t+1+`WORD_BITS`.
- `IDLE` is re-entered in cycle t+1+`WORD_BITS`+`GAP_CYCLES`.
- Under continuous requests, the frame period is `WORD_BITS+GAP_CYCLES+1` cycles: 6 cycles at defaults.
- Fairness: with all `req` bits held high, grant order is 0,1,…,`NREQ-1`,0,… and no requester waits more than `NREQ-1` frames.

## Test plan
- Reset check: assert `reset` with `req=4'hF` held. All outputs must stay 0 and no `ack` pulses. After releasing `reset`, the first grant goes to requester 0.
- Single frame: `req=4'b0010` with requester 1's word `4'b1101`. Expect:
  - `ack=4'b0010` and `owner=1` in cycle t+1;
  - `serial_out` 1,1,0,1 over cycles t+1..t+4 with `serial_valid=1`;
  - `frame_done` at t+5, `busy` low at t+6.
- Simultaneous requests: `req=4'b0101` right after reset, both held until acked. Requester 0 is served first and requester 2 second; the second `ack` arrives 6 cycles after the first.
- Rotation: `req=4'hF` held permanently. Grant order is 0,1,2,3,0 with `ack` pulses exactly 6 cycles apart.
- Mid-frame reset: assert `reset` during bit 2 of requester 3's word. On the next edge all outputs are 0, no `frame_done` is issued, and a following `req=4'b1001` grants requester 0 first.
- Late request and word change: a `req[2]` pulse occurring entirely within `SHIFT` is never granted. Changing requester 1's word during its `SHIFT` leaves the serial bits equal to the word latched at grant.
